// File: rtl/tiny_cpu_prog_loader_if.sv
// Pin-side byte strobe/data and instruction-memory write port of the program loader.
// The master drives the pins and observes memory writes and load status.
interface tiny_cpu_prog_loader_if #(
  parameter int unsigned ADDR_W = 5
);
  logic              strb_in;
  logic [7:0]        data_in;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              load_done;
  logic              load_err;

  modport master (
    output strb_in, data_in,
    input  mem_we, mem_addr, mem_wdata, cpu_hold, busy, load_done, load_err
  );

  modport slave (
    input  strb_in, data_in,
    output mem_we, mem_addr, mem_wdata, cpu_hold, busy, load_done, load_err
  );
endinterface

// File: rtl/tiny_cpu_prog_loader.sv
// Receives a framed, checksummed program image byte-by-byte from the pins, writes it into
// instruction memory and releases the CPU core from reset only after a verified load.
module tiny_cpu_prog_loader #(
  parameter int unsigned ADDR_W = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  tiny_cpu_prog_loader_if.slave  bus
);

  localparam int unsigned DEPTH     = 1 << ADDR_W;
  localparam int unsigned CNT_W     = ADDR_W + 1;
  localparam logic [7:0]  SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_HI, S_LO, S_CHK, S_DONE, S_ERR
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        sync_q;
  logic [7:0]        sum_q, sum_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        hi_q, hi_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              hold_q, hold_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              byte_ev;
  logic [7:0]        byte_v;

  // Two synchronizer stages plus one history stage for rising-edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 3'b000;
    else     sync_q <= {sync_q[1:0], bus.strb_in};
  end

  assign byte_ev = sync_q[1] & ~sync_q[2];
  assign byte_v  = bus.data_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sum_q   <= 8'h00;
      cnt_q   <= '0;
      hi_q    <= 8'h00;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= 16'h0000;
      hold_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    addr_d  = addr_q;
    we_d    = 1'b0;
    wdata_d = wdata_q;
    err_d   = err_q;

    // Address advances the cycle after the write pulse.
    if (we_q) addr_d = addr_q + ADDR_W'(1);

    if (byte_ev) begin
      case (state_q)
        S_IDLE, S_ERR: begin
          if (byte_v == SYNC_BYTE) begin
            state_d = S_LEN;
            sum_d   = 8'h00;
            addr_d  = '0;
            err_d   = 1'b0;
          end
        end
        S_LEN: begin
          if (32'(byte_v) > DEPTH) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            sum_d   = byte_v;
            cnt_d   = CNT_W'(byte_v);
            state_d = (byte_v == 8'h00) ? S_CHK : S_HI;
          end
        end
        S_HI: begin
          hi_d    = byte_v;
          sum_d   = sum_q + byte_v;
          state_d = S_LO;
        end
        S_LO: begin
          sum_d   = sum_q + byte_v;
          we_d    = 1'b1;
          wdata_d = {hi_q, byte_v};
          cnt_d   = cnt_q - CNT_W'(1);
          state_d = (cnt_q == CNT_W'(1)) ? S_CHK : S_HI;
        end
        S_CHK: begin
          if (byte_v == sum_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
        default: ;
      endcase
    end

    done_d = (state_d == S_DONE);
    hold_d = (state_d != S_DONE);
    busy_d = (state_d == S_LEN) || (state_d == S_HI) ||
             (state_d == S_LO)  || (state_d == S_CHK);
  end

  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.cpu_hold  = hold_q;
  assign bus.busy      = busy_q;
  assign bus.load_done = done_q;
  assign bus.load_err  = err_q;

endmodule

// File: tb/tb_tiny_cpu_prog_loader.sv
// Self-checking bench for tiny_cpu_prog_loader: table vectors, corner-case sequences and
// random frames checked against a byte-position frame parser model.
module tb_tiny_cpu_prog_loader;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b1;

  tiny_cpu_prog_loader_if #(.ADDR_W(ADDR_W)) bus ();
  tiny_cpu_prog_loader #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Write log captured from the memory port, plus pulse-width and address-step checks.
  logic [ADDR_W-1:0] log_a[$];
  logic [15:0]       log_d[$];
  logic              prev_we = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_we = 1'b0;
    end else begin
      if (prev_we) begin
        check("we_one_cycle", 32'(bus.mem_we), 32'(1'b0));
        check("addr_step", 32'(bus.mem_addr), 32'(ADDR_W'(prev_addr + ADDR_W'(1))));
      end
      if (bus.mem_we) begin
        log_a.push_back(bus.mem_addr);
        log_d.push_back(bus.mem_wdata);
      end
      prev_we   = bus.mem_we;
      prev_addr = bus.mem_addr;
    end
  end

  // Reference model: walks the byte stream by position within a frame.
  logic [ADDR_W-1:0] m_a[$];
  logic [15:0]       m_d[$];
  bit                m_done, m_err, m_busy;

  task automatic model_run(input logic [7:0] q[$]);
    bit         in_frame = 0;
    bit         got_len  = 0;
    int         len      = 0;
    int         k        = 0;
    logic [7:0] sum      = 8'h00;
    logic [7:0] hi       = 8'h00;
    m_a.delete();
    m_d.delete();
    m_done = 0;
    m_err  = 0;
    foreach (q[i]) begin
      if (m_done) continue;
      if (!in_frame) begin
        if (q[i] == 8'hA5) begin in_frame = 1; got_len = 0; m_err = 0; end
      end else if (!got_len) begin
        if (32'(q[i]) > DEPTH) begin m_err = 1; in_frame = 0; end
        else begin len = int'(q[i]); sum = q[i]; got_len = 1; k = 0; end
      end else if (k < 2 * len) begin
        sum = sum + q[i];
        if (k % 2 == 0) hi = q[i];
        else begin m_a.push_back(ADDR_W'(k / 2)); m_d.push_back({hi, q[i]}); end
        k++;
      end else begin
        if (q[i] == sum) m_done = 1; else m_err = 1;
        in_frame = 0;
      end
    end
    m_busy = in_frame;
  endtask

  task automatic send_byte(input logic [7:0] b, input int hi_cyc, input int lo_cyc);
    bus.data_in = b;
    @(posedge clk);
    #2 bus.strb_in = 1'b1;
    repeat (hi_cyc) @(posedge clk);
    #2 bus.strb_in = 1'b0;
    repeat (lo_cyc) @(posedge clk);
  endtask

  task automatic send_seq(input logic [7:0] q[$], input int hmin, input int hmax);
    foreach (q[i]) send_byte(q[i], $urandom_range(hmax, hmin), $urandom_range(5, 3));
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.strb_in = 1'b0;
    #3 rst = 1'b1;
    repeat (2) @(posedge clk);
    log_a.delete();
    log_d.delete();
    #3 rst = 1'b0;
    @(posedge clk);
  endtask

  task automatic compare_model(input string tag, input logic [7:0] q[$]);
    model_run(q);
    check({tag, "_nwr"}, 32'(log_a.size()), 32'(m_a.size()));
    for (int i = 0; i < log_a.size() && i < m_a.size(); i++) begin
      check({tag, "_waddr"}, 32'(log_a[i]), 32'(m_a[i]));
      check({tag, "_wdata"}, 32'(log_d[i]), 32'(m_d[i]));
    end
    check({tag, "_done"}, 32'(bus.load_done), 32'(m_done));
    check({tag, "_err"},  32'(bus.load_err),  32'(m_err));
    check({tag, "_hold"}, 32'(bus.cpu_hold),  32'(!m_done));
    check({tag, "_busy"}, 32'(bus.busy),      32'(m_busy));
  endtask

  typedef struct {
    string        name;
    int           n;
    logic [127:0] bytes;   // right-aligned, first byte most significant
    int           exp_we;
    logic [15:0]  w0;
    logic [15:0]  w1;
    logic         done;
    logic         err;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [7:0] q[$];
    logic [7:0] good[$];
    int         cnt;
    logic [7:0] s;

    bus.strb_in = 1'b0;
    bus.data_in = 8'h00;
    good = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC0};

    vecs[0] = '{"good", 7, 128'({8'hA5,8'h02,8'h12,8'h34,8'hAB,8'hCD,8'hC0}),
                2, 16'h1234, 16'hABCD, 1'b1, 1'b0};
    vecs[1] = '{"bad_chk", 7, 128'({8'hA5,8'h02,8'h12,8'h34,8'hAB,8'hCD,8'hC1}),
                2, 16'h1234, 16'hABCD, 1'b0, 1'b1};
    vecs[2] = '{"junk_good", 10, 128'({8'h00,8'hFF,8'h5A,8'hA5,8'h02,8'h12,8'h34,8'hAB,8'hCD,8'hC0}),
                2, 16'h1234, 16'hABCD, 1'b1, 1'b0};
    vecs[3] = '{"oversize", 2, 128'({8'hA5,8'h21}), 0, 16'h0, 16'h0, 1'b0, 1'b1};
    vecs[4] = '{"empty", 3, 128'({8'hA5,8'h00,8'h00}), 0, 16'h0, 16'h0, 1'b1, 1'b0};
    vecs[5] = '{"after_done", 12, 128'({8'hA5,8'h02,8'h12,8'h34,8'hAB,8'hCD,8'hC0,
                                        8'hA5,8'h01,8'h00,8'h00,8'h01}),
                2, 16'h1234, 16'hABCD, 1'b1, 1'b0};
    vecs[6] = '{"bad_then_good", 14, 128'({8'hA5,8'h02,8'h12,8'h34,8'hAB,8'hCD,8'hC1,
                                           8'hA5,8'h02,8'h12,8'h34,8'hAB,8'hCD,8'hC0}),
                4, 16'h1234, 16'hABCD, 1'b1, 1'b0};
    vecs[7] = '{"err_then_empty", 5, 128'({8'hA5,8'h21,8'hA5,8'h00,8'h00}),
                0, 16'h0, 16'h0, 1'b1, 1'b0};
    vecs[8] = '{"sum_wrap", 5, 128'({8'hA5,8'h01,8'hFF,8'hFF,8'hFF}),
                1, 16'hFFFF, 16'h0, 1'b1, 1'b0};
    vecs[9] = '{"empty_bad_chk", 3, 128'({8'hA5,8'h00,8'h01}), 0, 16'h0, 16'h0, 1'b0, 1'b1};

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_we",    32'(bus.mem_we),    32'(1'b0));
    check("rst_addr",  32'(bus.mem_addr),  32'h0);
    check("rst_wdata", 32'(bus.mem_wdata), 32'h0);
    check("rst_hold",  32'(bus.cpu_hold),  32'(1'b1));
    check("rst_busy",  32'(bus.busy),      32'(1'b0));
    check("rst_done",  32'(bus.load_done), 32'(1'b0));
    check("rst_err",   32'(bus.load_err),  32'(1'b0));

    // Table vectors, each from reset
    foreach (vecs[v]) begin
      q.delete();
      for (int i = 0; i < vecs[v].n; i++) q.push_back(vecs[v].bytes[8*(vecs[v].n-1-i) +: 8]);
      do_reset();
      send_seq(q, 3, 4);
      check({vecs[v].name, "_we_count"}, 32'(log_d.size()), 32'(vecs[v].exp_we));
      if (vecs[v].exp_we >= 1 && log_d.size() >= 1) begin
        check({vecs[v].name, "_w0"}, 32'(log_d[0]), 32'(vecs[v].w0));
        check({vecs[v].name, "_a0"}, 32'(log_a[0]), 32'h0);
      end
      if (vecs[v].exp_we >= 2 && log_d.size() >= 2) begin
        check({vecs[v].name, "_w1"}, 32'(log_d[1]), 32'(vecs[v].w1));
        check({vecs[v].name, "_a1"}, 32'(log_a[1]), 32'h1);
      end
      check({vecs[v].name, "_done"}, 32'(bus.load_done), 32'(vecs[v].done));
      check({vecs[v].name, "_err"},  32'(bus.load_err),  32'(vecs[v].err));
      check({vecs[v].name, "_hold"}, 32'(bus.cpu_hold),  32'(!vecs[v].done));
      check({vecs[v].name, "_busy"}, 32'(bus.busy),      32'(1'b0));
      compare_model(vecs[v].name, q);
    end

    // Preamble junk keeps the loader idle
    do_reset();
    q = '{8'h00, 8'hFF, 8'h5A};
    foreach (q[i]) begin
      send_byte(q[i], 3, 4);
      @(negedge clk);
      check("junk_busy", 32'(bus.busy), 32'(1'b0));
    end
    check("junk_no_we", 32'(log_d.size()), 32'h0);
    send_byte(8'hA5, 3, 4);
    @(negedge clk);
    check("sync_busy", 32'(bus.busy), 32'(1'b1));

    // load_err latency after an oversize LEN byte
    do_reset();
    send_byte(8'hA5, 3, 4);
    bus.data_in = 8'h21;
    @(posedge clk);
    #2 bus.strb_in = 1'b1;
    cnt = 0;
    do begin
      @(posedge clk);
      cnt++;
      #1;
    end while (!bus.load_err && cnt < 12);
    check("err_latency_ok", 32'(cnt >= 2 && cnt <= 4), 32'h1);
    check("err_hold", 32'(bus.cpu_hold), 32'(1'b1));
    repeat (3) @(posedge clk);
    #2 bus.strb_in = 1'b0;
    repeat (4) @(posedge clk);
    check("oversize_no_we", 32'(log_d.size()), 32'h0);

    // Reset in the middle of a frame, before the LO byte
    do_reset();
    q = '{8'hA5, 8'h02, 8'h12};
    send_seq(q, 3, 4);
    check("midrst_busy_before", 32'(bus.busy), 32'(1'b1));
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("midrst_no_we", 32'(log_d.size()), 32'h0);
    check("midrst_addr",  32'(bus.mem_addr), 32'h0);
    check("midrst_hold",  32'(bus.cpu_hold), 32'(1'b1));
    check("midrst_busy",  32'(bus.busy),     32'(1'b0));
    check("midrst_err",   32'(bus.load_err), 32'(1'b0));
    send_seq(good, 3, 4);
    compare_model("midrst_good", good);

    // Strobe held high for 50 cycles per byte
    do_reset();
    send_seq(good, 50, 50);
    compare_model("long_strobe", good);

    // Maximum length: 32 words filling addr 0..31
    do_reset();
    q = '{8'hA5, 8'h20};
    s = 8'h20;
    for (int i = 0; i < 64; i++) begin
      q.push_back(8'($urandom));
      s = s + q[q.size()-1];
    end
    q.push_back(s);
    send_seq(q, 3, 4);
    compare_model("len32", q);
    if (log_a.size() == 32) check("len32_last_addr", 32'(log_a[31]), 32'd31);
    else check("len32_count", 32'(log_a.size()), 32'd32);

    // Random frames with junk, oversize lengths and corrupt checksums
    for (int t = 0; t < 14; t++) begin
      q.delete();
      repeat ($urandom_range(2, 0)) q.push_back(8'($urandom));
      repeat ($urandom_range(2, 1)) begin
        int len;
        q.push_back(8'hA5);
        len = $urandom_range(34, 0);
        q.push_back(8'(len));
        if (len <= 32) begin
          s = 8'(len);
          for (int i = 0; i < 2 * len; i++) begin
            q.push_back(8'($urandom));
            s = s + q[q.size()-1];
          end
          q.push_back(($urandom_range(3, 0) == 0) ? 8'(s + 8'($urandom_range(255, 1))) : s);
        end
      end
      do_reset();
      send_seq(q, 3, 5);
      compare_model("rand", q);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tiny_cpu_prog_loader.md
# tiny_cpu_prog_loader

Program loader that sits directly upstream of the tiny CPU core. It receives a framed program image byte-by-byte from the dedicated input pins and assembles 16-bit instruction words. It writes those words into the core's instruction memory and holds the core in reset until a checksum-verified load completes. The chip-level wrapper routes the pin strobe and data into this block and drives the core's hold from `cpu_hold`.

## Interface
- `ADDR_W`, 5, instruction-memory address width; capacity = 2^ADDR_W words
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `strb_in`  in  1  byte strobe from pin, asynchronous to `clk`; a byte is taken on each rising edge
- `data_in`  in  8  byte value from pins; stable from before `strb_in` rises until ≥3 `clk` cycles after
- `mem_we`  out  1  one-cycle instruction-memory write enable
- `mem_addr`  out  ADDR_W  write word address
- `mem_wdata`  out  16  write word, {hi byte, lo byte}
- `cpu_hold`  out  1  1 = core held in reset; 0 only after a successful load
- `busy`  out  1  1 while a frame is in progress (states LEN, HI, LO, CHK)
- `load_done`  out  1  sticky 1 after a successful load
- `load_err`  out  1  sticky 1 after a failed frame, until the next sync byte

## Operation
- Frame format: 0xA5 (sync), LEN (word count), LEN × {HI, LO}, CHK.
- CHK must equal (LEN + all data bytes) mod 256.
- `strb_in` passes through a 2-FF synchronizer; a third FF gives rising-edge detect `byte_ev`.
- `data_in` is sampled in the cycle `byte_ev` is high. Exactly one event is produced per strobe rising edge, however long the strobe stays high.
- FSM states: IDLE, LEN, HI, LO, CHK, DONE, ERR.
  - IDLE: byte 0xA5 → LEN, clear sum, addr := 0. Any other byte is ignored.
  - LEN:
    - LEN > 2^ADDR_W → ERR.
    - LEN = 0 → CHK.
    - Otherwise store count, sum := LEN, → HI.
  - HI: latch hi byte, add to sum → LO.
  - LO: add to sum; next cycle pulse `mem_we` with {hi, lo} at current addr, then addr += 1, count −= 1.
    - count reaches 0 → CHK; otherwise → HI.
  - CHK: byte == sum → DONE, else → ERR.
  - DONE: `cpu_hold` = 0, `load_done` = 1. All further strobes are ignored until `rst`.
  - ERR: `load_err` = 1, `cpu_hold` = 1. Byte 0xA5 clears `load_err` and → LEN as from IDLE. Other bytes are ignored.
- Words already written by a failed frame stay in memory; `cpu_hold` keeps the core from using them.
- `sum` is 8 bits and wraps modulo 256. `mem_addr` never exceeds 2^ADDR_W − 1 because of the LEN check.

## Timing
- Reset values: `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, `cpu_hold` = 1, `busy` = 0, `load_done` = 0, `load_err` = 0, state IDLE, synchronizer FFs 0.
- Reset is asynchronous and takes effect mid-frame without any write. Memory contents are not cleared.
- Strobe-to-event latency: `byte_ev` is high in the 3rd `clk` edge after `strb_in` rises (±1 cycle for metastability resolution).
- `mem_we`, `mem_addr`, and `mem_wdata` are registered and valid in the same cycle. `mem_we` is high for exactly 1 cycle, the cycle after the LO byte event. `mem_addr` increments in the following cycle.
- Minimum strobe period: 6 `clk` cycles (3 high, 3 low).
- `cpu_hold` falls, and `load_done` rises, 1 cycle after the CHK byte event. The CHK byte event and the last `mem_we` never coincide because the events are ≥6 cycles apart.
- `load_err` rises 1 cycle after the offending LEN or CHK byte event.

## Test plan
- Good load, `ADDR_W` = 5: send A5,02,12,34,AB,CD,C0.
  - Expect `mem_we` pulses: addr 0 ← 0x1234, addr 1 ← 0xABCD.
  - Then `load_done` = 1, `cpu_hold` = 0, `busy` = 0.
- Bad checksum: send A5,02,12,34,AB,CD,C1.
  - Expect 2 writes, then `load_err` = 1 and `cpu_hold` = 1.
  - Resend the good frame: expect `load_err` = 0, `load_done` = 1, writes at addr 0 and 1 again.
- Preamble junk: send 00,FF,5A before the good frame.
  - Expect no `mem_we` and `busy` = 0 until A5.
  - Then the load completes identically to the good-load case.
- Oversize length: send A5,21.
  - Expect `load_err` = 1 one cycle after the LEN event and no `mem_we`.
  - LEN 0x20 followed by 32 words with a correct CHK loads addr 0..31.
- Reset mid-frame: send A5,02,12, pulse `rst` for 1 cycle before the LO byte.
  - Expect no `mem_we`, `mem_addr` = 0, `cpu_hold` = 1, state IDLE.
  - A following good frame succeeds.
- Strobe robustness:
  - Hold `strb_in` high for 50 cycles per byte: expect exactly one event per byte.
  - After DONE, send A5,01,00,00,01: expect no `mem_we` and `cpu_hold` stays 0.
  - Send A5,00,00 (empty program): expect DONE with no writes.
